// File: rtl/sone_pipe_if.sv
// Handshake/data bundle for sone_pipe: control, mux operands and pipeline outputs.
// With SONE_PIPE_PARITY_EN defined the bundle also carries out_par.
interface sone_pipe_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 1,
   parameter int CNT_W = $clog2(DEPTH + 1)
);
   logic             en;
   logic             sclr;
   logic             in_valid;
   logic [WIDTH-1:0] d0;
   logic [WIDTH-1:0] d1;
   logic [WIDTH-1:0] d2;
   logic [WIDTH-1:0] d3;
   logic [WIDTH-1:0] a0;
   logic [WIDTH-1:0] a1;
   logic [WIDTH-1:0] b0;
   logic [WIDTH-1:0] b1;
   logic [WIDTH-1:0] out;
   logic             out_valid;
   logic [CNT_W-1:0] occ;
`ifdef SONE_PIPE_PARITY_EN
   logic             out_par;

   modport master (
      output en, sclr, in_valid, d0, d1, d2, d3, a0, a1, b0, b1,
      input  out, out_valid, occ, out_par
   );
   modport slave (
      input  en, sclr, in_valid, d0, d1, d2, d3, a0, a1, b0, b1,
      output out, out_valid, occ, out_par
   );
`else
   modport master (
      output en, sclr, in_valid, d0, d1, d2, d3, a0, a1, b0, b1,
      input  out, out_valid, occ
   );
   modport slave (
      input  en, sclr, in_valid, d0, d1, d2, d3, a0, a1, b0, b1,
      output out, out_valid, occ
   );
`endif
endinterface

// File: rtl/sone_pipe.sv
// sone_pipe: WIDTH per-bit 4:1 mux cells feeding a DEPTH-stage valid-tagged pipeline
// with stall, synchronous clear and occupancy count. Optional macro: SONE_PIPE_PARITY_EN.
module sone_pipe #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 1,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic        clk,
   input  logic        CLR,
   sone_pipe_if.slave  bus
);

   function automatic logic [WIDTH-1:0] mux_cells(
      input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
      input logic [WIDTH-1:0] d2, input logic [WIDTH-1:0] d3,
      input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] a1,
      input logic [WIDTH-1:0] b0, input logic [WIDTH-1:0] b1
   );
      logic [WIDTH-1:0] hi;
      logic [WIDTH-1:0] lo;
      hi = b0 | b1;
      lo = a0 & a1;
      return (hi & lo & d3) | (hi & ~lo & d2) | (~hi & lo & d1) | (~hi & ~lo & d0);
   endfunction

   function automatic logic even_par(input logic [WIDTH-1:0] v);
      return ^v;
   endfunction

   logic [WIDTH-1:0] m_s;
   logic [WIDTH-1:0] data_q [DEPTH];
   logic [WIDTH-1:0] data_d [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] valid_d;
   logic [CNT_W-1:0] occ_q;
   logic [CNT_W-1:0] occ_d;
`ifdef SONE_PIPE_PARITY_EN
   logic [DEPTH-1:0] par_q;
   logic [DEPTH-1:0] par_d;
`endif

   // Stage-0 operand: the per-bit mux selection.
   always_comb begin
      m_s = mux_cells(bus.d0, bus.d1, bus.d2, bus.d3, bus.a0, bus.a1, bus.b0, bus.b1);
   end

   // Next state: sclr clears, en shifts, otherwise everything holds.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      occ_d   = occ_q;
`ifdef SONE_PIPE_PARITY_EN
      par_d   = par_q;
`endif
      if (bus.sclr) begin
         data_d  = '{default: '0};
         valid_d = '0;
         occ_d   = '0;
`ifdef SONE_PIPE_PARITY_EN
         par_d   = '0;
`endif
      end else if (bus.en) begin
         data_d[0]  = m_s;
         valid_d[0] = bus.in_valid;
`ifdef SONE_PIPE_PARITY_EN
         par_d[0]   = even_par(m_s);
`endif
         for (int k = 1; k < DEPTH; k++) begin
            data_d[k]  = data_q[k-1];
            valid_d[k] = valid_q[k-1];
`ifdef SONE_PIPE_PARITY_EN
            par_d[k]   = par_q[k-1];
`endif
         end
         // One word in and one out on the same edge leaves the count unchanged.
         occ_d = occ_q + CNT_W'(bus.in_valid) - CNT_W'(valid_q[DEPTH-1]);
      end else begin
         occ_d = occ_q;
      end
   end

   // Pipeline state registers with asynchronous clear.
   always_ff @(posedge clk or posedge CLR) begin
      if (CLR) begin
         data_q  <= '{default: '0};
         valid_q <= '0;
         occ_q   <= '0;
`ifdef SONE_PIPE_PARITY_EN
         par_q   <= '0;
`endif
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         occ_q   <= occ_d;
`ifdef SONE_PIPE_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign bus.out       = data_q[DEPTH-1];
   assign bus.out_valid = valid_q[DEPTH-1];
   assign bus.occ       = occ_q;
`ifdef SONE_PIPE_PARITY_EN
   assign bus.out_par   = par_q[DEPTH-1];
`endif

endmodule

// File: tb/tb_sone_pipe.sv
// Self-checking bench for sone_pipe: WIDTH=4 DEPTH=3 main instance plus a DEPTH=1 instance
// sharing its inputs; queue model checked every cycle plus literal expectations.
module tb_sone_pipe;
   localparam int W  = 4;
   localparam int D  = 3;
   localparam int CW = $clog2(D + 1);

   logic clk;
   logic CLR;
   int   checks;
   int   errors;
   logic check_en;

   sone_pipe_if #(.WIDTH(W), .DEPTH(D)) bus ();
   sone_pipe_if #(.WIDTH(W), .DEPTH(1)) bus1 ();

   assign bus1.en       = bus.en;
   assign bus1.sclr     = bus.sclr;
   assign bus1.in_valid = bus.in_valid;
   assign bus1.d0       = bus.d0;
   assign bus1.d1       = bus.d1;
   assign bus1.d2       = bus.d2;
   assign bus1.d3       = bus.d3;
   assign bus1.a0       = bus.a0;
   assign bus1.a1       = bus.a1;
   assign bus1.b0       = bus.b0;
   assign bus1.b1       = bus.b1;

   sone_pipe #(.WIDTH(W), .DEPTH(D)) dut  (.clk(clk), .CLR(CLR), .bus(bus));
   sone_pipe #(.WIDTH(W), .DEPTH(1)) dut1 (.clk(clk), .CLR(CLR), .bus(bus1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] d;
      logic         v;
      logic         p;
   } word_t;

   word_t mq[$];

   function automatic logic [W-1:0] ref_mux(input int unsigned i0, input int unsigned i1,
                                            input int unsigned i2, input int unsigned i3,
                                            input int unsigned x0, input int unsigned x1,
                                            input int unsigned y0, input int unsigned y1);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) begin
         bit hi;
         bit lo;
         hi = y0[i] || y1[i];
         lo = x0[i] && x1[i];
         r[i] = hi ? (lo ? i3[i] : i2[i]) : (lo ? i1[i] : i0[i]);
      end
      return r;
   endfunction

   task automatic model_clear();
      word_t z;
      z = '0;
      mq.delete();
      for (int i = 0; i < D; i++) mq.push_back(z);
   endtask

   // Model: fixed-length queue, newest word at the front.
   always @(posedge clk or posedge CLR) begin
      if (CLR || bus.sclr) begin
         model_clear();
      end else if (bus.en) begin
         word_t w;
         w.d = ref_mux(bus.d0, bus.d1, bus.d2, bus.d3, bus.a0, bus.a1, bus.b0, bus.b1);
         w.v = bus.in_valid;
         w.p = ^w.d;
         mq.push_front(w);
         void'(mq.pop_back());
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle compare of both instances against the model.
   always @(negedge clk) begin
      if (check_en) begin
         int cnt;
         cnt = 0;
         foreach (mq[i]) if (mq[i].v) cnt++;
         chk("cyc_out",        32'(bus.out),        32'(mq[D-1].d));
         chk("cyc_out_valid",  32'(bus.out_valid),  32'(mq[D-1].v));
         chk("cyc_occ",        32'(bus.occ),        32'(cnt));
         chk("cyc1_out",       32'(bus1.out),       32'(mq[0].d));
         chk("cyc1_out_valid", 32'(bus1.out_valid), 32'(mq[0].v));
         chk("cyc1_occ",       32'(bus1.occ),       32'(mq[0].v));
`ifdef SONE_PIPE_PARITY_EN
         chk("cyc_par",        32'(bus.out_par),    32'(mq[D-1].p));
         chk("cyc1_par",       32'(bus1.out_par),   32'(mq[0].p));
`endif
      end
   end

   task automatic step(input logic e, input logic s, input logic v);
      bus.en = e;
      bus.sclr = s;
      bus.in_valid = v;
      @(posedge clk);
      #1;
   endtask

   task automatic set_sel(input logic [W-1:0] x0, input logic [W-1:0] x1,
                          input logic [W-1:0] y0, input logic [W-1:0] y1);
      bus.a0 = x0; bus.a1 = x1; bus.b0 = y0; bus.b1 = y1;
   endtask

   task automatic set_dat(input logic [W-1:0] i0, input logic [W-1:0] i1,
                          input logic [W-1:0] i2, input logic [W-1:0] i3);
      bus.d0 = i0; bus.d1 = i1; bus.d2 = i2; bus.d3 = i3;
   endtask

   task automatic one_word();
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      check_en = 1'b0;
      CLR = 1'b0;
      bus.en = 1'b0; bus.sclr = 1'b0; bus.in_valid = 1'b0;
      set_dat(4'h0, 4'h0, 4'h0, 4'h0);
      set_sel(4'h0, 4'h0, 4'h0, 4'h0);
      #1 CLR = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out", 32'(bus.out), 32'h0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
      chk("rst_occ", 32'(bus.occ), 32'h0);
      CLR = 1'b0;
      check_en = 1'b1;

      // Mux selection.
      set_dat(4'h1, 4'h2, 4'h4, 4'h8);
      set_sel(4'hF, 4'hF, 4'h0, 4'h0);
      one_word();
      chk("mux_lo", 32'(bus.out), 32'h2);
      chk("mux_lo_valid", 32'(bus.out_valid), 32'h1);
      bus.b1 = 4'hF;
      one_word();
      chk("mux_hilo", 32'(bus.out), 32'h8);
      bus.a1 = 4'h0; bus.b0 = 4'hF;
      one_word();
      chk("mux_hi", 32'(bus.out), 32'h4);
      set_sel(4'h3, 4'h3, 4'h5, 4'h0);
      set_dat(4'h0, 4'hF, 4'h0, 4'hF);
      one_word();
      chk("mux_mix", 32'(bus.out), 32'h3);
      repeat (3) step(1'b1, 1'b0, 1'b0);
      chk("drain_occ", 32'(bus.occ), 32'h0);

      // Stall with three words in flight.
      set_sel(4'h0, 4'h0, 4'h0, 4'h0);
      set_dat(4'h5, 4'h0, 4'h0, 4'h0);
      step(1'b1, 1'b0, 1'b1); chk("stall_occ1", 32'(bus.occ), 32'h1);
      bus.d0 = 4'hA;
      step(1'b1, 1'b0, 1'b1); chk("stall_occ2", 32'(bus.occ), 32'h2);
      bus.d0 = 4'hC;
      step(1'b1, 1'b0, 1'b1); chk("stall_occ3", 32'(bus.occ), 32'h3);
      chk("stall_outA", 32'(bus.out), 32'h5);
      bus.d0 = 4'hF;
      step(1'b0, 1'b0, 1'b1); chk("stall_hold_occ", 32'(bus.occ), 32'h3);
      step(1'b0, 1'b0, 1'b1); chk("stall_hold_out", 32'(bus.out), 32'h5);
      step(1'b1, 1'b0, 1'b0); chk("stall_outB", 32'(bus.out), 32'hA);
      chk("stall_drain2", 32'(bus.occ), 32'h2);
      step(1'b1, 1'b0, 1'b0); chk("stall_outC", 32'(bus.out), 32'hC);
      chk("stall_drain1", 32'(bus.occ), 32'h1);
      step(1'b1, 1'b0, 1'b0); chk("stall_empty_valid", 32'(bus.out_valid), 32'h0);
      chk("stall_drain0", 32'(bus.occ), 32'h0);

      // Synchronous clear while stalled.
      bus.d0 = 4'h6;
      step(1'b1, 1'b0, 1'b1);
      bus.d0 = 4'h9;
      step(1'b1, 1'b0, 1'b1);
      chk("sclr_pre_occ", 32'(bus.occ), 32'h2);
      step(1'b0, 1'b1, 1'b1);
      chk("sclr_occ", 32'(bus.occ), 32'h0);
      chk("sclr_valid", 32'(bus.out_valid), 32'h0);
      chk("sclr_out", 32'(bus.out), 32'h0);
      bus.d0 = 4'h7;
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      chk("sclr_lat_early", 32'(bus.out_valid), 32'h0);
      step(1'b1, 1'b0, 1'b0);
      chk("sclr_lat_out", 32'(bus.out), 32'h7);
      chk("sclr_lat_valid", 32'(bus.out_valid), 32'h1);

      // Asynchronous clear with the pipe full.
      bus.d0 = 4'h1; step(1'b1, 1'b0, 1'b1);
      bus.d0 = 4'h2; step(1'b1, 1'b0, 1'b1);
      bus.d0 = 4'h3; step(1'b1, 1'b0, 1'b1);
      chk("full_occ", 32'(bus.occ), 32'h3);
      #2 CLR = 1'b1;
      #1;
      chk("clr_out", 32'(bus.out), 32'h0);
      chk("clr_valid", 32'(bus.out_valid), 32'h0);
      chk("clr_occ", 32'(bus.occ), 32'h0);
      @(posedge clk);
      #1;
      chk("clr_hold_occ", 32'(bus.occ), 32'h0);
      CLR = 1'b0;
      step(1'b1, 1'b0, 1'b1);
      chk("clr_restart_occ", 32'(bus.occ), 32'h1);

      // Single-stage instance, parity when enabled.
      bus.d0 = 4'h7;
      step(1'b1, 1'b0, 1'b1);
      chk("d1_out7", 32'(bus1.out), 32'h7);
      chk("d1_valid", 32'(bus1.out_valid), 32'h1);
`ifdef SONE_PIPE_PARITY_EN
      chk("d1_par7", 32'(bus1.out_par), 32'h1);
`endif
      bus.d0 = 4'h3;
      step(1'b1, 1'b0, 1'b1);
      chk("d1_out3", 32'(bus1.out), 32'h3);
`ifdef SONE_PIPE_PARITY_EN
      chk("d1_par3", 32'(bus1.out_par), 32'h0);
`endif
      repeat (4) step(1'b1, 1'b0, 1'b0);
      check_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
